alu_op_scheduler: RTL and testbench



---
 rtl/alu_sched_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/alu_op_scheduler.sv | 154 +++++++++++++++
 tb/tb_alu_op_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StHold,
    StWait,
    StCapt
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned DEFAULT_CNT_W   = 8;

  // During WAIT the ALU expects the M operand zero-extended on the input bus.
  function automatic logic [15:0] m_operand(input logic [7:0] opm);
    return {8'h00, opm};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the other port on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one multi-cycle ALU between two requesters: arbitrates, replays the
// ALU load protocol, waits for finish with a timeout and returns the result.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  sel0,
  input  logic [1:0]  sel1,
  input  logic [15:0] opa0,
  input  logic [15:0] opa1,
  input  logic [7:0]  opm0,
  input  logic [7:0]  opm1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        err,
  output logic        busy,
  output logic        alu_rst,
  output logic        alu_start,
  output logic [1:0]  alu_sel,
  output logic [15:0] alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_finish
);

  state_e            state_q;
  logic              port_q;
  logic [1:0]        sel_q;
  logic [15:0]       opa_q;
  logic [7:0]        opm_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       grant_win;
  logic       arb_adv;
  logic       wait_exit;

  // A grant may be issued from IDLE, or on the CAPT->IDLE edge so that a
  // waiting port is granted in the first IDLE cycle. In CAPT the port just
  // served is masked: its request may legally still be high from the old op.
  always_comb begin
    arb_req   = {req1, req0};
    grant_win = 1'b0;
    if (state_q == StIdle) begin
      grant_win = !(gnt0 || gnt1);
    end else if (state_q == StCapt) begin
      grant_win = 1'b1;
      arb_req   = {req1, req0} & (port_q ? 2'b01 : 2'b10);
    end
    arb_adv   = grant_win && (arb_gnt != 2'b00);
    wait_exit = alu_finish || (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      port_q    <= 1'b0;
      sel_q     <= 2'b00;
      opa_q     <= '0;
      opm_q     <= '0;
      cnt_q     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      alu_rst   <= 1'b1;
      alu_start <= 1'b0;
      alu_sel   <= 2'b00;
      alu_inbus <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      alu_rst   <= 1'b0;
      alu_start <= 1'b0;

      if (arb_adv) begin
        gnt0   <= arb_gnt[0];
        gnt1   <= arb_gnt[1];
        port_q <= arb_gnt[1];
        sel_q  <= arb_gnt[1] ? sel1 : sel0;
        opa_q  <= arb_gnt[1] ? opa1 : opa0;
        opm_q  <= arb_gnt[1] ? opm1 : opm0;
      end

      unique case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            state_q <= StClr;
            alu_rst <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StClr: begin
          state_q   <= StStart;
          alu_start <= 1'b1;
          alu_sel   <= sel_q;
          alu_inbus <= opa_q;
        end
        StStart: begin
          state_q   <= StHold;
          alu_inbus <= opa_q;
        end
        StHold: begin
          state_q   <= StWait;
          cnt_q     <= '0;
          alu_inbus <= m_operand(opm_q);
        end
        StWait: begin
          if (wait_exit) begin
            state_q   <= StCapt;
            alu_inbus <= '0;
            err       <= !alu_finish;
            result    <= alu_finish ? alu_outbus : 16'h0000;
            done0     <= !port_q;
            done1     <= port_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StCapt: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed testbench for alu_op_scheduler with a behavioural ALU stub.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int unsigned TB_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [1:0]  sel0 = '0, sel1 = '0;
  logic [15:0] opa0 = '0, opa1 = '0;
  logic [7:0]  opm0 = '0, opm1 = '0;
  logic        gnt0, gnt1, done0, done1, err, busy;
  logic [15:0] result;
  logic        alu_rst, alu_start;
  logic [1:0]  alu_sel;
  logic [15:0] alu_inbus;
  logic [15:0] alu_outbus;
  logic        alu_finish;

  int checks = 0;
  int failures = 0;

  // Stub: finish rises stub_d cycles after the start cycle (0 = never).
  logic [15:0] stub_out = '0;
  int          stub_d = 0;
  logic        stub_sticky = 1'b0;
  int          stub_cnt = 0;
  logic        stub_fin = 1'b0;

  assign alu_outbus = stub_out;
  assign alu_finish = stub_fin | stub_sticky;

  always @(posedge clk) begin
    if (alu_rst) begin
      stub_cnt <= 0;
      stub_fin <= 1'b0;
    end else if (alu_start) begin
      stub_cnt <= 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_d != 0 && stub_cnt + 1 == stub_d) stub_fin <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  alu_op_scheduler #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .sel0       (sel0),
    .sel1       (sel1),
    .opa0       (opa0),
    .opa1       (opa1),
    .opm0       (opm0),
    .opm1       (opm1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .alu_rst    (alu_rst),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish)
  );

  task automatic issue(input int port, input logic [1:0] s, input logic [15:0] a,
                       input logic [7:0] m);
    if (port == 0) begin
      sel0 = s; opa0 = a; opm0 = m; req0 = 1'b1;
    end else begin
      sel1 = s; opa1 = a; opm1 = m; req1 = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    flags = {gnt0, gnt1, done0, done1, err, busy, alu_rst, alu_start, alu_sel};
    checks++;
    if (flags !== 10'b0000001000) begin
      failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 10'b0000001000);
    end
    checks++;
    if ({result, alu_inbus} !== 32'h0) begin
      failures++; $display("FAIL reset_buses got=%h exp=0", {result, alu_inbus});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (alu_rst !== 1'b1) begin
      failures++; $display("FAIL reset_alu_rst_hold got=%b exp=1", alu_rst);
    end
    @(negedge clk);
    checks++;
    if (alu_rst !== 1'b0) begin
      failures++; $display("FAIL reset_alu_rst_release got=%b exp=0", alu_rst);
    end
  endtask

  task automatic test_add();
    logic early;
    stub_out = 16'd52; stub_d = 5;
    issue(0, OP_ADD, 16'd40, 8'd12);
    @(negedge clk);  // T0
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++; $display("FAIL add_gnt got=%b exp=10", {gnt0, gnt1});
    end
    req0 = 1'b0; opa0 = 16'hFFFF; opm0 = 8'hFF; sel0 = OP_DIV;
    @(negedge clk);  // T1
    checks++;
    if ({alu_rst, busy, alu_start, gnt0} !== 4'b1100) begin
      failures++; $display("FAIL add_clr got=%b exp=1100", {alu_rst, busy, alu_start, gnt0});
    end
    @(negedge clk);  // T2
    checks++;
    if ({alu_start, alu_sel, alu_inbus} !== {1'b1, OP_ADD, 16'd40}) begin
      failures++; $display("FAIL add_start got=%b/%b/%0d exp=1/00/40", alu_start, alu_sel,
                           alu_inbus);
    end
    @(negedge clk);  // T3
    checks++;
    if ({alu_start, alu_inbus} !== {1'b0, 16'd40}) begin
      failures++; $display("FAIL add_hold got=%b/%0d exp=0/40", alu_start, alu_inbus);
    end
    @(negedge clk);  // T4
    checks++;
    if (alu_inbus !== 16'd12) begin
      failures++; $display("FAIL add_wait_inbus got=%0d exp=12", alu_inbus);
    end
    early = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      if (done0 || done1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL add_early_done got=%b exp=0", early);
    end
    @(negedge clk);  // T8
    checks++;
    if ({done0, done1, err, result} !== {3'b100, 16'd52}) begin
      failures++; $display("FAIL add_done got=%b%b%b/%0d exp=100/52", done0, done1, err, result);
    end
    @(negedge clk);  // T9
    checks++;
    if ({done0, busy} !== 2'b00) begin
      failures++; $display("FAIL add_idle got=%b exp=00", {done0, busy});
    end
  endtask

  task automatic test_div();
    stub_out = {8'd67, 8'd85}; stub_d = 3;
    issue(1, OP_DIV, 16'd11542, 8'd135);
    @(negedge clk);  // T0
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      failures++; $display("FAIL div_gnt got=%b exp=01", {gnt0, gnt1});
    end
    req1 = 1'b0; opa1 = 16'h0; opm1 = 8'h0;
    repeat (2) @(negedge clk);  // T2
    checks++;
    if ({alu_start, alu_sel, alu_inbus} !== {1'b1, OP_DIV, 16'd11542}) begin
      failures++; $display("FAIL div_start got=%b/%b/%0d exp=1/11/11542", alu_start, alu_sel,
                           alu_inbus);
    end
    @(negedge clk);  // T3
    checks++;
    if (alu_inbus !== 16'd11542) begin
      failures++; $display("FAIL div_hold got=%0d exp=11542", alu_inbus);
    end
    @(negedge clk);  // T4
    checks++;
    if ({alu_sel, alu_inbus} !== {OP_DIV, 16'd135}) begin
      failures++; $display("FAIL div_wait got=%b/%0d exp=11/135", alu_sel, alu_inbus);
    end
    repeat (2) @(negedge clk);  // T6
    checks++;
    if ({done0, done1, err, result} !== {3'b010, 16'h4355}) begin
      failures++; $display("FAIL div_done got=%b%b%b/%h exp=010/4355", done0, done1, err, result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 2; rep++) begin
      int t_g0 = -1, t_g1 = -1, t_d0 = -1, t_d1 = -1;
      logic both = 1'b0;
      stub_out = 16'h00AA; stub_d = 2;
      issue(0, OP_ADD, 16'd1, 8'd2);
      issue(1, OP_SUB, 16'd9, 8'd4);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (gnt0 && gnt1) both = 1'b1;
        if (gnt0 && t_g0 < 0) begin t_g0 = c; req0 = 1'b0; end
        if (gnt1 && t_g1 < 0) begin t_g1 = c; req1 = 1'b0; end
        if (done0 && t_d0 < 0) t_d0 = c;
        if (done1 && t_d1 < 0) t_d1 = c;
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (t_g0 != 0 || both) begin
        failures++; $display("FAIL b2b_first_port0 rep=%0d got=g0@%0d both=%b exp=g0@0", rep,
                             t_g0, both);
      end
      checks++;
      if (t_g1 != 6) begin
        failures++; $display("FAIL b2b_gnt_spacing rep=%0d got=%0d exp=6", rep, t_g1);
      end
      checks++;
      if (t_d0 != 5 || t_d1 != 11) begin
        failures++; $display("FAIL b2b_done rep=%0d got=%0d,%0d exp=5,11", rep, t_d0, t_d1);
      end
    end
  endtask

  task automatic test_timeout();
    logic early;
    stub_out = 16'h1234; stub_d = 0;
    issue(0, OP_SUB, 16'd5, 8'd3);
    @(negedge clk);  // T0
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++; $display("FAIL to_gnt got=%b exp=1", gnt0);
    end
    req0 = 1'b0;
    early = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (done0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL to_early_done got=%b exp=0", early);
    end
    @(negedge clk);  // T20
    checks++;
    if ({done0, err, result} !== {2'b11, 16'h0000}) begin
      failures++; $display("FAIL to_done got=%b%b/%h exp=11/0000", done0, err, result);
    end
    @(negedge clk);
    stub_out = 16'h0009; stub_d = 2;
    issue(0, OP_ADD, 16'd4, 8'd5);
    @(negedge clk);  // T0
    req0 = 1'b0;
    @(negedge clk);  // T1
    checks++;
    if (alu_rst !== 1'b1) begin
      failures++; $display("FAIL to_next_clr got=%b exp=1", alu_rst);
    end
    repeat (4) @(negedge clk);  // T5
    checks++;
    if ({done0, err, result} !== {2'b10, 16'h0009}) begin
      failures++; $display("FAIL to_next_done got=%b%b/%h exp=10/0009", done0, err, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [9:0] flags;
    logic       seen;
    stub_out = 16'd480; stub_d = 0;
    issue(0, OP_MUL, 16'd40, 8'd12);
    @(negedge clk);  // T0
    req0 = 1'b0;
    repeat (6) @(negedge clk);  // T6, in WAIT
    checks++;
    if ({busy, alu_inbus} !== {1'b1, 16'd12}) begin
      failures++; $display("FAIL mid_in_wait got=%b/%0d exp=1/12", busy, alu_inbus);
    end
    rst_n = 1'b0;
    #1;
    flags = {gnt0, gnt1, done0, done1, err, busy, alu_rst, alu_start, alu_sel};
    checks++;
    if (flags !== 10'b0000001000 || {result, alu_inbus} !== 32'h0) begin
      failures++; $display("FAIL mid_reset_outputs got=%b/%h exp=0000001000/0", flags,
                           {result, alu_inbus});
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (alu_rst !== 1'b1) begin
      failures++; $display("FAIL mid_alu_rst_hold got=%b exp=1", alu_rst);
    end
    @(negedge clk);
    if (done0 || done1) seen = 1'b1;
    checks++;
    if ({alu_rst, busy, seen} !== 3'b000) begin
      failures++; $display("FAIL mid_release got=%b exp=000", {alu_rst, busy, seen});
    end
    // Pointer must be back at port 0 after reset.
    stub_out = 16'd52; stub_d = 2;
    issue(0, OP_ADD, 16'd40, 8'd12);
    issue(1, OP_ADD, 16'd1, 8'd1);
    @(negedge clk);  // T0
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      failures++; $display("FAIL mid_ptr_reset got=%b exp=10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    repeat (5) @(negedge clk);  // T5
    checks++;
    if ({done0, err, result} !== {2'b10, 16'd52}) begin
      failures++; $display("FAIL mid_next_done got=%b%b/%0d exp=10/52", done0, err, result);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt1) req1 = 1'b0;
      if (done1) seen = 1'b1;
    end
    req1 = 1'b0;
    checks++;
    if (seen !== 1'b1) begin
      failures++; $display("FAIL mid_port1_drain got=%b exp=1", seen);
    end
  endtask

  task automatic test_stale_finish();
    logic early;
    stub_sticky = 1'b1; stub_d = 0; stub_out = 16'h0077;
    @(negedge clk);
    issue(1, OP_ADD, 16'd1, 8'd2);
    @(negedge clk);  // T0
    req1 = 1'b0;
    early = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL stale_early_done got=%b exp=0", early);
    end
    @(negedge clk);  // T5
    checks++;
    if ({done1, err, result} !== {2'b10, 16'h0077}) begin
      failures++; $display("FAIL stale_done got=%b%b/%h exp=10/0077", done1, err, result);
    end
    stub_sticky = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    test_stale_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
